usart_rx: RTL and testbench

- 8N1 asynchronous serial receiver. Companion stage to the existing transmitter path: it consumes the serial line that a usart_tx drives, and it feeds received bytes to the controller or CPU bus side.
- Samples the line at the system clock rate using a baud counter. The default divisor matches the transmitter's divisor of 138.
- Delivers each received byte with a valid/ack handshake, plus sticky overrun and framing-error flags.

---
 rtl/usart_rx.sv | 137 +++++++++++++
 tb/tb_usart_rx.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usart_rx.sv
// 8N1 asynchronous serial receiver. It samples at bit centres using a baud counter and
// delivers each byte through a valid/ack handshake with sticky overrun and framing flags.
module usart_rx #(
  parameter int unsigned CLKS_PER_BIT = 138
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_pin,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_overrun,
  output logic       rx_frame_error,
  output logic       rx_busy
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned CntW     = $clog2(CLKS_PER_BIT);

  localparam logic [CntW-1:0] CntHalf = CntW'(HALF_BIT - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] bit_cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            rx_meta_q;
  logic            rx_s_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= StIdle;
      bit_cnt_q      <= '0;
      bit_idx_q      <= '0;
      shift_q        <= '0;
      rx_meta_q      <= 1'b1;
      rx_s_q         <= 1'b1;
      rx_data        <= '0;
      rx_valid       <= 1'b0;
      rx_overrun     <= 1'b0;
      rx_frame_error <= 1'b0;
      rx_busy        <= 1'b0;
    end else begin
      rx_meta_q <= rx_pin;
      rx_s_q    <= rx_meta_q;

      // Ack clears first; a delivery or error in the same cycle overrides below.
      if (rx_ack) begin
        rx_valid       <= 1'b0;
        rx_overrun     <= 1'b0;
        rx_frame_error <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (!rx_s_q) begin
            state_q   <= StStart;
            bit_cnt_q <= '0;
            rx_busy   <= 1'b1;
          end
        end

        StStart: begin
          if (bit_cnt_q == CntHalf) begin
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            if (rx_s_q) begin
              state_q <= StIdle;
              rx_busy <= 1'b0;
            end else begin
              state_q <= StData;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end

        StData: begin
          if (bit_cnt_q == CntLast) begin
            bit_cnt_q <= '0;
            shift_q   <= {rx_s_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= StStop;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end

        StStop: begin
          if (bit_cnt_q == CntLast) begin
            bit_cnt_q <= '0;
            if (rx_s_q) begin
              state_q <= StIdle;
              rx_busy <= 1'b0;
              if (!rx_valid || rx_ack) begin
                rx_data  <= shift_q;
                rx_valid <= 1'b1;
              end else begin
                rx_overrun <= 1'b1;
              end
            end else begin
              rx_frame_error <= 1'b1;
              state_q        <= StBreak;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
          end
        end

        // Hold off until the line is released so a stuck-low line is not seen as starts.
        StBreak: begin
          if (rx_s_q) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            rx_busy   <= 1'b0;
          end
        end

        default: begin
          state_q <= StIdle;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usart_rx.sv
// Self-checking bench for usart_rx: an event-level model predicts every output each cycle
// from the frames the bench sends, plus literal checks of latency and handshake corners.
module tb_usart_rx;

  localparam int C  = 16;
  localparam int H  = C / 2;
  localparam int CD = 138;

  typedef struct {
    int         t;
    logic [7:0] b;
    bit         ok;
  } ev_t;

  logic       clk;
  logic       rst_n, rx_pin, rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid, rx_overrun, rx_frame_error, rx_busy;

  logic       rst_d_n, pin_d, ack_d;
  logic [7:0] data_d;
  logic       valid_d, ovr_d, fe_d, busy_d;

  int  total = 0;
  int  bad = 0;
  int  edge_n = 0;
  int  ack_at = -1;
  int  bs = 0;
  int  be = 0;
  int  last_rise = -1;
  bit  rand_ack = 1'b0;
  ev_t evq[$];

  logic [7:0] m_data;
  logic       m_valid, m_ovr, m_fe;
  logic       ack_prev = 1'b0;
  logic       rst_prev = 1'b0;

  usart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk           (clk),
    .reset_n       (rst_n),
    .rx_pin        (rx_pin),
    .rx_ack        (rx_ack),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_overrun    (rx_overrun),
    .rx_frame_error(rx_frame_error),
    .rx_busy       (rx_busy)
  );

  usart_rx dut_def (
    .clk           (clk),
    .reset_n       (rst_d_n),
    .rx_pin        (pin_d),
    .rx_ack        (ack_d),
    .rx_data       (data_d),
    .rx_valid      (valid_d),
    .rx_overrun    (ovr_d),
    .rx_frame_error(fe_d),
    .rx_busy       (busy_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic idle(input int n);
    if (n > 0) repeat (n) @(posedge clk);
    #1;
  endtask

  // Start bit is first sampled at edge t0; stop sample lands at t0 + 2 + H + 9*C.
  task automatic send_frame(input logic [7:0] b, input bit ok, input int tail,
                            input bit ack_stop, output int t0);
    logic [9:0] bits;
    int t, eh;
    bits = {ok, b, 1'b0};
    @(posedge clk);
    #1;
    t0 = edge_n + 1;
    t  = t0 + 2 + H + 9 * C;
    eh = t0 + 10 * C + tail;
    evq.push_back('{t, b, ok});
    bs = t0 + 2;
    be = ok ? t : ((t + 1 > eh + 2) ? t + 1 : eh + 2);
    if (ack_stop) ack_at = t;
    for (int k = 0; k < 10; k++) begin
      rx_pin = bits[k];
      repeat (C) @(posedge clk);
      #1;
    end
    if (!ok && tail > 0) begin
      repeat (tail) @(posedge clk);
      #1;
    end
    rx_pin = 1'b1;
  endtask

  task automatic glitch(input int len, output int busy_cnt);
    int t0;
    @(posedge clk);
    #1;
    t0 = edge_n + 1;
    bs = t0 + 2;
    be = t0 + 2 + H;
    busy_cnt = 0;
    rx_pin = 1'b0;
    for (int k = 0; k < len + 24; k++) begin
      if (k == len) rx_pin = 1'b1;
      @(posedge clk);
      #1;
      busy_cnt += int'(rx_busy);
    end
  endtask

  task automatic send_def(input logic [7:0] b, input int rst_from, input int rst_to,
                          output int rise);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    rise = -1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 10 * CD; k++) begin
      pin_d   = bits[k / CD];
      rst_d_n = !(k >= rst_from && k < rst_to);
      @(posedge clk);
      #1;
      if (valid_d && rise < 0) rise = k;
    end
    pin_d   = 1'b1;
    rst_d_n = 1'b1;
  endtask

  initial begin
    int t0, t1, cnt, rise, kind;
    rst_n   = 1'b0;
    rx_pin  = 1'b1;
    rx_ack  = 1'b0;
    rst_d_n = 1'b0;
    pin_d   = 1'b1;
    ack_d   = 1'b0;

    fork
      forever begin
        @(posedge clk);
        edge_n++;
      end
      forever begin
        @(posedge clk);
        #2;
        rx_ack = (edge_n + 1 == ack_at) || (rand_ack && $urandom_range(0, 11) == 0);
      end
      begin : cmp
        logic vb, prev_v;
        int   e;
        ev_t  ev;
        prev_v = 1'b0;
        forever begin
          @(negedge clk);
          e = edge_n;
          if (!rst_prev) begin
            m_data  = '0;
            m_valid = 1'b0;
            m_ovr   = 1'b0;
            m_fe    = 1'b0;
            evq.delete();
            bs = 0;
            be = 0;
          end else begin
            vb = m_valid;
            if (ack_prev) begin
              m_valid = 1'b0;
              m_ovr   = 1'b0;
              m_fe    = 1'b0;
            end
            while (evq.size() > 0 && evq[0].t <= e) begin
              ev = evq.pop_front();
              if (ev.t == e) begin
                if (!ev.ok) m_fe = 1'b1;
                else if (!vb || ack_prev) begin
                  m_data  = ev.b;
                  m_valid = 1'b1;
                end else m_ovr = 1'b1;
              end
            end
          end
          check("cyc_valid", rx_valid, m_valid);
          check("cyc_data", rx_data, m_data);
          check("cyc_overrun", rx_overrun, m_ovr);
          check("cyc_frame_error", rx_frame_error, m_fe);
          check("cyc_busy", rx_busy, (e >= bs && e < be));
          if (rx_valid && !prev_v) last_rise = e;
          prev_v   = rx_valid;
          ack_prev = rx_ack;
          rst_prev = rst_n;
        end
      end
    join_none

    idle(3);
    rst_n   = 1'b1;
    rst_d_n = 1'b1;
    idle(5);
    check("reset_valid", rx_valid, 0);
    check("reset_data", rx_data, 0);
    check("reset_flags", {rx_overrun, rx_frame_error, rx_busy}, 0);

    // Single byte latency and ack release.
    send_frame(8'h55, 1'b1, 0, 1'b0, t0);
    idle(2);
    check("single_latency", last_rise - t0, 154);
    check("single_data", rx_data, 8'h55);
    check("single_flags", {rx_overrun, rx_frame_error}, 0);
    ack_at = edge_n + 1;
    idle(1);
    check("single_ack_clears", rx_valid, 0);

    // False start.
    glitch(4, cnt);
    check("false_busy_le10", (cnt <= 10 && cnt > 0), 1);
    check("false_no_byte", rx_valid, 0);
    check("false_no_flags", {rx_overrun, rx_frame_error}, 0);
    idle(4);

    // Overrun.
    send_frame(8'hA3, 1'b1, 0, 1'b0, t0);
    send_frame(8'h3C, 1'b1, 0, 1'b0, t1);
    idle(2);
    check("ovr_data", rx_data, 8'hA3);
    check("ovr_valid", rx_valid, 1);
    check("ovr_flag", rx_overrun, 1);
    ack_at = edge_n + 1;
    idle(2);
    check("ovr_cleared", {rx_valid, rx_overrun, rx_frame_error}, 0);

    // Ack in exactly the stop-sample cycle of the second byte.
    send_frame(8'h5A, 1'b1, 0, 1'b0, t0);
    send_frame(8'h81, 1'b1, 0, 1'b1, t1);
    idle(2);
    check("coll_data", rx_data, 8'h81);
    check("coll_valid", rx_valid, 1);
    check("coll_no_ovr", rx_overrun, 0);
    ack_at = edge_n + 1;
    idle(3);

    // Framing error, line held low, then a good byte.
    send_frame(8'hFF, 1'b0, 40, 1'b0, t0);
    idle(4);
    check("brk_fe", rx_frame_error, 1);
    check("brk_no_byte", rx_valid, 0);
    send_frame(8'h12, 1'b1, 0, 1'b0, t1);
    idle(2);
    check("brk_next_data", rx_data, 8'h12);
    check("brk_next_valid", rx_valid, 1);
    check("brk_fe_sticky", rx_frame_error, 1);
    ack_at = edge_n + 1;
    idle(3);

    // Random traffic with random acks.
    rand_ack = 1'b1;
    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        glitch($urandom_range(1, H - 1), cnt);
      end else if (kind == 1) begin
        send_frame(8'($urandom), 1'b0, $urandom_range(0, 40), 1'b0, t0);
        idle($urandom_range(2, 12));
      end else begin
        send_frame(8'($urandom), 1'b1, 0, 1'b0, t0);
        idle($urandom_range(0, 20));
      end
    end
    rand_ack = 1'b0;
    idle(C * 12);

    // Default rate: reset in data bit 4 drops the frame, then a clean 0xC7.
    send_def(8'h00, 5 * CD + 30, 9 * CD + 20, rise);
    idle(2);
    check("def_rst_no_byte", (rise < 0), 1);
    check("def_rst_outputs", {data_d, valid_d, ovr_d, fe_d, busy_d}, 0);
    send_def(8'hC7, -1, -1, rise);
    idle(2);
    check("def_latency", rise, 2 + CD / 2 + 9 * CD);
    check("def_data", data_d, 8'hC7);
    check("def_valid", valid_d, 1);
    check("def_flags", {ovr_d, fe_d, busy_d}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
